// File: rtl/dma_controller.sv
// Block-oriented DMA engine: requests the memory bus, writes NUM_BLOCKS 4-word
// blocks from an external device and pulses an interrupt when the transfer completes.
module dma_controller #(
  parameter logic [15:0] BASE_ADDR  = 16'h01F4,
  parameter int unsigned NUM_BLOCKS = 3,
  parameter int unsigned WR_CYCLES  = 4
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        cmd,
  input  logic        BG,
  input  logic [63:0] edata,
  output logic        BR,
  output logic        WRITE,
  output logic [15:0] addr,
  output logic [63:0] data,
  output logic [1:0]  offset,
  output logic        interrupt
);

  localparam int unsigned CNT_W = $clog2(WR_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         block_q, block_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      block_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    block_d   = block_q;
    cnt_d     = cnt_q;
    BR        = 1'b0;
    WRITE     = 1'b0;
    interrupt = 1'b0;
    offset    = 2'd0;
    case (state_q)
      IDLE: begin
        if (cmd) begin
          block_d = 2'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        BR     = 1'b1;
        offset = block_q;
        if (BG) begin
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        BR     = 1'b1;
        offset = block_q;
        WRITE  = BG;
        // Losing the grant mid-block restarts that block from its first cycle.
        if (!BG) begin
          cnt_d   = '0;
          state_d = REQ;
        end else if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
          cnt_d = '0;
          if (block_q == 2'(NUM_BLOCKS - 1)) begin
            state_d = DONE;
          end else begin
            block_d = block_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        interrupt = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr = BASE_ADDR + {12'd0, block_q, 2'b00};
  assign data = edata;

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: default instance plus a wraparound
// instance (BASE_ADDR=FFFC, two blocks of two write cycles).
module tb_dma_controller;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        cmd, BG;
  logic        cmd_b, BG_b;
  logic [63:0] edata;

  logic        BR, WRITE, interrupt;
  logic [15:0] addr;
  logic [63:0] data;
  logic [1:0]  offset;

  logic        BR_b, WRITE_b, interrupt_b;
  logic [15:0] addr_b;
  logic [63:0] data_b;
  logic [1:0]  offset_b;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dma_controller dut (
    .CLK(CLK), .reset_n(reset_n), .cmd(cmd), .BG(BG), .edata(edata),
    .BR(BR), .WRITE(WRITE), .addr(addr), .data(data), .offset(offset),
    .interrupt(interrupt)
  );

  dma_controller #(.BASE_ADDR(16'hFFFC), .NUM_BLOCKS(2), .WR_CYCLES(2)) dut_b (
    .CLK(CLK), .reset_n(reset_n), .cmd(cmd_b), .BG(BG_b), .edata(edata),
    .BR(BR_b), .WRITE(WRITE_b), .addr(addr_b), .data(data_b), .offset(offset_b),
    .interrupt(interrupt_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    cmd = 1'b0; BG = 1'b0; cmd_b = 1'b0; BG_b = 1'b0;
    edata = 64'h1111_2222_3333_4444;
    #1;
    chk("rst_BR", BR, 1'b0);
    chk("rst_WRITE", WRITE, 1'b0);
    chk("rst_int", interrupt, 1'b0);
    chk("rst_addr", addr, 16'h01F4);
    chk("rst_offset", offset, 2'd0);
    chk("rst_addr_b", addr_b, 16'hFFFC);
    step; step;
    reset_n = 1'b1;

    // Basic transfer, grant one cycle after request
    cmd = 1'b1;
    step;
    cmd = 1'b0;
    chk("t1_req_BR", BR, 1'b1);
    chk("t1_req_WRITE", WRITE, 1'b0);
    BG = 1'b1;
    step;
    for (int i = 0; i < 12; i++) begin
      chk("t1_WRITE", WRITE, 1'b1);
      chk("t1_BR", BR, 1'b1);
      chk("t1_addr", addr, 16'h01F4 + 4 * (i / 4));
      chk("t1_offset", offset, i / 4);
      step;
    end
    chk("t1_done_BR", BR, 1'b0);
    chk("t1_done_WRITE", WRITE, 1'b0);
    chk("t1_done_int", interrupt, 1'b1);
    step;
    chk("t1_idle_int", interrupt, 1'b0);
    chk("t1_data", data, 64'h1111_2222_3333_4444);
    edata = 64'hDEAD_BEEF_0123_4567;
    #1;
    chk("t1_data2", data, 64'hDEAD_BEEF_0123_4567);

    // Cycle stealing during block 1; BG high in IDLE has no effect
    step;
    chk("t2_idle_BR", BR, 1'b0);
    chk("t2_idle_WRITE", WRITE, 1'b0);
    cmd = 1'b1;
    step;
    cmd = 1'b0;
    step;
    for (int i = 0; i < 4; i++) begin
      chk("t2_b0_addr", addr, 16'h01F4);
      chk("t2_b0_WRITE", WRITE, 1'b1);
      step;
    end
    chk("t2_b1_addr", addr, 16'h01F8);
    chk("t2_b1_WRITE", WRITE, 1'b1);
    step;
    BG = 1'b0;
    #1;
    chk("t2_steal_WRITE", WRITE, 1'b0);
    chk("t2_steal_BR", BR, 1'b1);
    step;
    chk("t2_req1_WRITE", WRITE, 1'b0);
    chk("t2_req1_BR", BR, 1'b1);
    chk("t2_req1_offset", offset, 2'd1);
    chk("t2_req1_addr", addr, 16'h01F8);
    step;
    chk("t2_req2_WRITE", WRITE, 1'b0);
    chk("t2_req2_BR", BR, 1'b1);
    BG = 1'b1;
    #1;
    chk("t2_req2_WRITE_bg", WRITE, 1'b0);
    step;
    for (int i = 0; i < 4; i++) begin
      chk("t2_rb1_addr", addr, 16'h01F8);
      chk("t2_rb1_offset", offset, 2'd1);
      chk("t2_rb1_WRITE", WRITE, 1'b1);
      step;
    end
    for (int i = 0; i < 4; i++) begin
      chk("t2_b2_addr", addr, 16'h01FC);
      chk("t2_b2_offset", offset, 2'd2);
      chk("t2_b2_WRITE", WRITE, 1'b1);
      step;
    end
    chk("t2_done_int", interrupt, 1'b1);
    step;
    chk("t2_idle_int", interrupt, 1'b0);

    // cmd held high: one transfer per acceptance
    cmd = 1'b1;
    step;
    step;
    for (int i = 0; i < 12; i++) begin
      chk("t3_WRITE", WRITE, 1'b1);
      chk("t3_addr", addr, 16'h01F4 + 4 * (i / 4));
      step;
    end
    chk("t3_done_int", interrupt, 1'b1);
    chk("t3_done_BR", BR, 1'b0);
    step;
    chk("t3_idle_BR", BR, 1'b0);
    chk("t3_idle_int", interrupt, 1'b0);
    chk("t3_idle_WRITE", WRITE, 1'b0);
    step;
    chk("t3_req_BR", BR, 1'b1);
    chk("t3_req_WRITE", WRITE, 1'b0);
    cmd = 1'b0;
    step;
    chk("t3_x_addr", addr, 16'h01F4);
    for (int i = 0; i < 8; i++) step;
    chk("t3_b2_addr", addr, 16'h01FC);
    step;

    // Asynchronous reset during block 2
    reset_n = 1'b0;
    #1;
    chk("t4_rst_BR", BR, 1'b0);
    chk("t4_rst_WRITE", WRITE, 1'b0);
    chk("t4_rst_int", interrupt, 1'b0);
    chk("t4_rst_addr", addr, 16'h01F4);
    chk("t4_rst_offset", offset, 2'd0);
    step;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_int", interrupt, 1'b0);
      chk("t4_idle_BR", BR, 1'b0);
      step;
    end
    cmd = 1'b1;
    step;
    cmd = 1'b0;
    step;
    chk("t4_restart_addr", addr, 16'h01F4);
    chk("t4_restart_offset", offset, 2'd0);
    chk("t4_restart_WRITE", WRITE, 1'b1);

    // Grant never given
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    BG = 1'b0;
    cmd = 1'b1;
    step;
    cmd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("t5_BR", BR, 1'b1);
      chk("t5_WRITE", WRITE, 1'b0);
      chk("t5_int", interrupt, 1'b0);
      step;
    end

    // Wraparound instance
    BG_b = 1'b1;
    cmd_b = 1'b1;
    step;
    cmd_b = 1'b0;
    chk("t6_req_BR", BR_b, 1'b1);
    step;
    for (int i = 0; i < 4; i++) begin
      chk("t6_addr", addr_b, (i < 2) ? 16'hFFFC : 16'h0000);
      chk("t6_offset", offset_b, i / 2);
      chk("t6_WRITE", WRITE_b, 1'b1);
      step;
    end
    chk("t6_done_int", interrupt_b, 1'b1);
    chk("t6_done_BR", BR_b, 1'b0);
    step;
    chk("t6_idle_int", interrupt_b, 1'b0);
    chk("t6_data", data_b, 64'hDEAD_BEEF_0123_4567);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
